bridge_arbiter: RTL and testbench

Two-master arbiter placed in front of the peripheral bridge.
- Master 0 is the CPU memory stage; master 1 is a DMA/debug engine.
- It serialises their requests onto the single PrAddr/PrWD/PrWe/PrRD bridge port and sequences each access over a fixed number of cycles.
- It returns the read data to the winning master with a one-cycle ack pulse.

---
 rtl/bridge_arbiter.sv | 146 ++++++++++++++
 tb/tb_bridge_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bridge_arbiter.sv
// Two-master arbiter in front of the peripheral bridge: picks one request,
// holds the bridge port for ACCESS_CYCLES cycles, then acks the winner with read data.
module bridge_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 1,
  parameter bit          FIXED_PRIO    = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wd,
  input  logic        m0_we,
  output logic        m0_ack,
  output logic [31:0] m0_rd,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wd,
  input  logic        m1_we,
  output logic        m1_ack,
  output logic [31:0] m1_rd,
  output logic [31:0] PrAddr,
  output logic [31:0] PrWD,
  output logic        PrWe,
  input  logic [31:0] PrRD,
  output logic        owner,
  output logic        busy
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] LAST_CNT = CW'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [AW-1:0] lat_addr, lat_addr_n;
  logic [DW-1:0] lat_wd, lat_wd_n;
  logic          lat_we, lat_we_n;
  logic          owner_n, last_grant, last_grant_n, winner;
  logic          m0_ack_n, m1_ack_n;
  logic [DW-1:0] m0_rd_n, m1_rd_n;
  logic [AW-1:0] pr_addr_n;
  logic [DW-1:0] pr_wd_n;
  logic          pr_we_n, busy_n;

  // State and registered outputs; reset clears the bus immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      lat_addr   <= '0;
      lat_wd     <= '0;
      lat_we     <= 1'b0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      m0_rd      <= '0;
      m1_rd      <= '0;
      PrAddr     <= '0;
      PrWD       <= '0;
      PrWe       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      lat_addr   <= lat_addr_n;
      lat_wd     <= lat_wd_n;
      lat_we     <= lat_we_n;
      owner      <= owner_n;
      last_grant <= last_grant_n;
      m0_ack     <= m0_ack_n;
      m1_ack     <= m1_ack_n;
      m0_rd      <= m0_rd_n;
      m1_rd      <= m1_rd_n;
      PrAddr     <= pr_addr_n;
      PrWD       <= pr_wd_n;
      PrWe       <= pr_we_n;
      busy       <= busy_n;
    end
  end

  // Next state, grant decision and next values of the registered outputs
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    lat_addr_n   = lat_addr;
    lat_wd_n     = lat_wd;
    lat_we_n     = lat_we;
    owner_n      = owner;
    last_grant_n = last_grant;
    m0_rd_n      = m0_rd;
    m1_rd_n      = m1_rd;
    m0_ack_n     = 1'b0;
    m1_ack_n     = 1'b0;
    winner       = 1'b0;
    pr_addr_n    = '0;
    pr_wd_n      = '0;
    pr_we_n      = 1'b0;

    unique case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          if (m0_req && m1_req) winner = FIXED_PRIO ? 1'b0 : ~last_grant;
          else                  winner = m1_req;
          owner_n    = winner;
          lat_addr_n = winner ? {m1_addr[AW-1:2], 2'b00} : {m0_addr[AW-1:2], 2'b00};
          lat_wd_n   = winner ? m1_wd : m0_wd;
          lat_we_n   = winner ? m1_we : m0_we;
          cnt_n      = '0;
          state_n    = ACCESS;
        end
      end
      ACCESS: begin
        cnt_n = cnt + CW'(1);
        if (cnt == LAST_CNT) begin
          state_n = ACK;
          // Ack and data are registered here so they are valid during ACK
          if (owner) begin
            m1_rd_n  = PrRD;
            m1_ack_n = 1'b1;
          end else begin
            m0_rd_n  = PrRD;
            m0_ack_n = 1'b1;
          end
        end
      end
      ACK: begin
        last_grant_n = owner;
        state_n      = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Write strobe only in the first access cycle: one write per transaction
    if (state_n == ACCESS) begin
      pr_addr_n = lat_addr_n;
      pr_wd_n   = lat_wd_n;
      pr_we_n   = lat_we_n && (cnt_n == '0);
    end
    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_bridge_arbiter.sv
// Bench for bridge_arbiter: three configurations share stimulus and are compared
// every cycle against a transaction-phase reference model, plus directed scenarios.
module tb_bridge_arbiter;

  localparam int unsigned NI = 3;
  localparam int unsigned AC_TAB [NI] = '{1, 3, 4};
  localparam bit          FP_TAB [NI] = '{1'b0, 1'b1, 1'b0};

  logic        clk, reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wd, m1_addr, m1_wd, PrRD;

  logic        m0_ack [NI];
  logic        m1_ack [NI];
  logic [31:0] m0_rd  [NI];
  logic [31:0] m1_rd  [NI];
  logic [31:0] pr_addr[NI];
  logic [31:0] pr_wd  [NI];
  logic        pr_we  [NI];
  logic        owner  [NI];
  logic        busy   [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    bridge_arbiter #(.ACCESS_CYCLES(AC_TAB[g]), .FIXED_PRIO(FP_TAB[g])) u_dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_wd(m0_wd), .m0_we(m0_we),
      .m0_ack(m0_ack[g]), .m0_rd(m0_rd[g]),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_wd(m1_wd), .m1_we(m1_we),
      .m1_ack(m1_ack[g]), .m1_rd(m1_rd[g]),
      .PrAddr(pr_addr[g]), .PrWD(pr_wd[g]), .PrWe(pr_we[g]), .PrRD(PrRD),
      .owner(owner[g]), .busy(busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: ph = -1 idle, 0..AC-1 index of the access cycle, AC = ack cycle
  int          ph  [NI];
  logic        ow  [NI];
  logic        lg  [NI];
  logic [31:0] ma  [NI];
  logic [31:0] mw  [NI];
  logic        mwe [NI];
  logic [31:0] r0  [NI];
  logic [31:0] r1  [NI];

  always @(posedge clk or negedge reset) begin
    for (int i = 0; i < NI; i++) begin
      if (!reset) begin
        ph[i] = -1; ow[i] = 1'b0; lg[i] = 1'b1; ma[i] = '0; mw[i] = '0;
        mwe[i] = 1'b0; r0[i] = '0; r1[i] = '0;
      end else if (ph[i] < 0) begin
        if (m0_req || m1_req) begin
          if (m0_req && m1_req) ow[i] = FP_TAB[i] ? 1'b0 : !lg[i];
          else                  ow[i] = m1_req;
          ma[i]  = (ow[i] ? m1_addr : m0_addr) & 32'hFFFF_FFFC;
          mw[i]  = ow[i] ? m1_wd : m0_wd;
          mwe[i] = ow[i] ? m1_we : m0_we;
          ph[i]  = 0;
        end
      end else if (ph[i] < int'(AC_TAB[i])) begin
        if (ph[i] == int'(AC_TAB[i]) - 1) begin
          if (ow[i]) r1[i] = PrRD;
          else       r0[i] = PrRD;
        end
        ph[i] = ph[i] + 1;
      end else begin
        lg[i] = ow[i];
        ph[i] = -1;
      end
    end
  end

  // Observation counters for the directed scenarios
  int          n_ack0[NI];
  int          n_ack1[NI];
  int          n_we  [NI];
  int          n_acc [NI];
  int          n_overlap;
  int          glog[$];
  logic [31:0] tgt;

  task automatic clr();
    for (int i = 0; i < NI; i++) begin
      n_ack0[i] = 0; n_ack1[i] = 0; n_we[i] = 0; n_acc[i] = 0;
    end
    n_overlap = 0;
    glog.delete();
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      check($sformatf("u%0d.PrAddr", i), pr_addr[i],
            (ph[i] >= 0 && ph[i] < int'(AC_TAB[i])) ? ma[i] : 32'h0);
      check($sformatf("u%0d.PrWD", i), pr_wd[i],
            (ph[i] >= 0 && ph[i] < int'(AC_TAB[i])) ? mw[i] : 32'h0);
      check($sformatf("u%0d.PrWe", i), 32'(pr_we[i]), 32'(ph[i] == 0 && mwe[i]));
      check($sformatf("u%0d.busy", i), 32'(busy[i]), 32'(ph[i] >= 0));
      check($sformatf("u%0d.owner", i), 32'(owner[i]), 32'(ow[i]));
      check($sformatf("u%0d.m0_ack", i), 32'(m0_ack[i]), 32'(ph[i] == int'(AC_TAB[i]) && !ow[i]));
      check($sformatf("u%0d.m1_ack", i), 32'(m1_ack[i]), 32'(ph[i] == int'(AC_TAB[i]) && ow[i]));
      check($sformatf("u%0d.m0_rd", i), m0_rd[i], r0[i]);
      check($sformatf("u%0d.m1_rd", i), m1_rd[i], r1[i]);
      n_ack0[i] += int'(m0_ack[i]);
      n_ack1[i] += int'(m1_ack[i]);
      n_we[i]   += int'(pr_we[i]);
      n_acc[i]  += int'(pr_addr[i] == tgt);
      if (m0_ack[i] && m1_ack[i]) n_overlap++;
    end
    if (m0_ack[0]) glog.push_back(0);
    if (m1_ack[0]) glog.push_back(1);
  end

  task automatic apply_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
  endtask

  int lat;

  initial begin
    reset = 1'b0; m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
    m0_addr = '0; m0_wd = '0; m1_addr = '0; m1_wd = '0; PrRD = '0; tgt = 32'hFFFF_FFFF;
    clr();
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #2;
    check("rst.busy", 32'(busy[0]), 32'h0);
    check("rst.PrAddr", pr_addr[2], 32'h0);

    // Single read by m0
    clr(); tgt = 32'h0000_7F04; PrRD = 32'h1234_5678;
    m0_addr = 32'h0000_7F04; m0_we = 1'b0; m0_req = 1'b1;
    @(posedge clk); #2 m0_req = 1'b0;
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (m0_ack[0] && lat == 0) lat = k;
    end
    check("t1.u0.ack_latency", lat, 2);
    check("t1.u0.m0_rd", m0_rd[0], 32'h1234_5678);
    check("t1.u0.addr_cycles", n_acc[0], 1);
    check("t1.u0.m1_acks", n_ack1[0], 0);
    @(posedge clk); #2;

    // Single write by m0, observed on the 3-cycle instance
    clr(); tgt = 32'h0000_7F34; PrRD = 32'hA5A5_0001;
    m0_addr = 32'h0000_7F34; m0_wd = 32'hDEAD_BEEF; m0_we = 1'b1; m0_req = 1'b1;
    @(posedge clk); #2 m0_req = 1'b0;
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (m0_ack[1] && lat == 0) lat = k;
    end
    check("t2.u1.ack_latency", lat, 4);
    check("t2.u1.we_cycles", n_we[1], 1);
    check("t2.u1.addr_cycles", n_acc[1], 3);
    @(posedge clk); #2;

    // Both masters requesting continuously
    apply_reset();
    clr(); tgt = 32'hFFFF_FFFF; m0_we = 1'b0; m1_we = 1'b0;
    m0_addr = 32'h0000_1000; m1_addr = 32'h0000_2000; m0_req = 1'b1; m1_req = 1'b1;
    repeat (20) @(posedge clk);
    #2 m0_req = 1'b0; m1_req = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    check("t3.u0.grant_count_ok", 32'(glog.size() >= 4), 32'h1);
    for (int j = 0; j < 4 && j < glog.size(); j++)
      check($sformatf("t3.u0.grant%0d", j), glog[j], j % 2);
    check("t3.u1.m1_acks", n_ack1[1], 0);
    check("t3.u1.m0_acks", n_ack0[1], 4);
    check("t3.ack_overlap", n_overlap, 0);

    // Unaligned m1 address, req dropped during access
    clr(); tgt = 32'h0000_7F04; PrRD = 32'h0BAD_F00D;
    m1_addr = 32'h0000_7F07; m1_we = 1'b0; m1_req = 1'b1;
    @(posedge clk); #2 m1_req = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    check("t4.u2.m1_acks", n_ack1[2], 1);
    check("t4.u2.addr_cycles", n_acc[2], 4);
    check("t4.u0.m1_acks", n_ack1[0], 1);

    // Reset in the second access cycle of the 4-cycle instance
    clr(); tgt = 32'hFFFF_FFFF;
    m0_addr = 32'h0000_7F40; m0_wd = 32'h5555_AAAA; m0_we = 1'b1; m0_req = 1'b1;
    @(posedge clk); #2 m0_req = 1'b0;
    @(posedge clk); #2;
    check("t5.u2.busy_before", 32'(busy[2]), 32'h1);
    check("t5.u2.addr_before", pr_addr[2], 32'h0000_7F40);
    reset = 1'b0;
    #1;
    check("t5.u2.PrWe", 32'(pr_we[2]), 32'h0);
    check("t5.u2.PrAddr", pr_addr[2], 32'h0);
    check("t5.u2.busy", 32'(busy[2]), 32'h0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    repeat (8) @(posedge clk);
    #2;
    check("t5.u2.no_ack", n_ack0[2] + n_ack1[2], 0);
    clr();
    m0_we = 1'b0; m1_we = 1'b0; m0_req = 1'b1; m1_req = 1'b1;
    @(posedge clk); #2 m0_req = 1'b0; m1_req = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    check("t5.u2.first_tie_m0", n_ack0[2], 1);
    check("t5.u2.first_tie_m1", n_ack1[2], 0);

    // Randomized traffic with occasional asynchronous resets
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #2;
      m0_req  = ($urandom_range(0, 3) != 0);
      m1_req  = ($urandom_range(0, 3) != 0);
      m0_we   = 1'($urandom_range(0, 1));
      m1_we   = 1'($urandom_range(0, 1));
      m0_addr = $urandom; m1_addr = $urandom;
      m0_wd   = $urandom; m1_wd   = $urandom;
      PrRD    = $urandom;
      reset   = ($urandom_range(0, 299) != 0);
    end
    @(posedge clk); #2 reset = 1'b1;
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
